cdb_arbiter: RTL and testbench

Common Data Bus arbiter for the Tomasulo back end. It takes completed results from up to NUM_SRC functional-unit reservation stations (MUL_RS, ALU RS, load unit, …) through a valid/ready handshake and buffers one result per source. Each cycle it grants at most one buffered result by round-robin and drives the registered `out_CDB_broadcast`/`out_CDB_tag`/`out_CDB_val` bus. All reservation stations and the register status table snoop that bus through their `in_CDB_*` inputs.

---
 rtl/cdb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter for the Tomasulo back end.
//
// Every producer source has one holding slot. Each cycle, at most one
// buffered result is granted by round-robin, and the grant drives the
// registered CDB broadcast bus. A result whose tag is INVALID_TAG is never
// broadcast: its slot is flushed one cycle after it loads, and out_drop
// pulses for that cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_src_valid[i]     source i offers a result (tag/val packed per source)
//   out_src_ready[i]    slot i is empty or is being granted this cycle
//   out_CDB_*           registered broadcast bus (valid pulse, tag, value,
//                       granted source index)
//   out_drop            pulse: one or more INVALID_TAG results were discarded
//   out_pending         count of occupied holding slots

module cdb_slot #(
   parameter int TAG_W = 5,
   parameter int VAL_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             clr_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic [VAL_W-1:0] val_i,
   output logic             hv_o,
   output logic [TAG_W-1:0] tag_o,
   output logic [VAL_W-1:0] val_o
);
   logic             hv_q;
   logic [TAG_W-1:0] tag_q;
   logic [VAL_W-1:0] val_q;

   // A load takes priority over a clear. This lets a granted slot refill
   // in the same cycle with no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         hv_q  <= 1'b0;
         tag_q <= '1;
         val_q <= '0;
      end else if (load_i) begin
         hv_q  <= 1'b1;
         tag_q <= tag_i;
         val_q <= val_i;
      end else if (clr_i) begin
         hv_q  <= 1'b0;
      end
   end

   assign hv_o  = hv_q;
   assign tag_o = tag_q;
   assign val_o = val_q;
endmodule

module cdb_arbiter #(
   parameter int               NUM_SRC     = 4,
   parameter int               TAG_W       = 5,
   parameter int               VAL_W       = 32,
   parameter logic [TAG_W-1:0] INVALID_TAG = '1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SRC-1:0]           in_src_valid,
   input  logic [TAG_W*NUM_SRC-1:0]     in_src_tag,
   input  logic [VAL_W*NUM_SRC-1:0]     in_src_val,
   output logic [NUM_SRC-1:0]           out_src_ready,
   output logic                         out_CDB_broadcast,
   output logic [TAG_W-1:0]             out_CDB_tag,
   output logic [VAL_W-1:0]             out_CDB_val,
   output logic [$clog2(NUM_SRC)-1:0]   out_CDB_src,
   output logic                         out_drop,
   output logic [$clog2(NUM_SRC):0]     out_pending
);
   localparam int SRC_W  = $clog2(NUM_SRC);
   localparam int PEND_W = SRC_W + 1;

   logic [NUM_SRC-1:0]            hv, elig, inv_slot, grant, accept, clr, hv_d;
   logic [NUM_SRC-1:0][TAG_W-1:0] htag;
   logic [NUM_SRC-1:0][VAL_W-1:0] hval;

   logic [SRC_W-1:0]  rr_ptr_q, gnt_idx, cand;
   logic              gnt_any;
   logic              bcast_q, drop_q;
   logic [TAG_W-1:0]  tag_q;
   logic [VAL_W-1:0]  val_q;
   logic [SRC_W-1:0]  src_q;
   logic [PEND_W-1:0] pend_q, pend_d;

   // (base + k) mod NUM_SRC, for k < NUM_SRC. NUM_SRC need not be a power of 2.
   function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                 input int unsigned      k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= 32'(NUM_SRC)) s = s - 32'(NUM_SRC);
      return s[SRC_W-1:0];
   endfunction

   // Ready depends only on registered state (plus reset), never on valid.
   assign out_src_ready = rst ? '1 : (~hv | grant);
   assign accept        = in_src_valid & out_src_ready & {NUM_SRC{~rst}};
   assign clr           = grant | inv_slot;
   assign hv_d          = accept | (hv & ~clr);

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
      assign inv_slot[i] = hv[i] & (htag[i] == INVALID_TAG);
      assign elig[i]     = hv[i] & (htag[i] != INVALID_TAG);

      cdb_slot #(.TAG_W(TAG_W), .VAL_W(VAL_W)) u_slot (
         .clk    (clk),
         .rst    (rst),
         .load_i (accept[i]),
         .clr_i  (clr[i]),
         .tag_i  (in_src_tag[i*TAG_W +: TAG_W]),
         .val_i  (in_src_val[i*VAL_W +: VAL_W]),
         .hv_o   (hv[i]),
         .tag_o  (htag[i]),
         .val_o  (hval[i])
      );
   end

   // Round-robin: the first eligible slot at or after rr_ptr_q.
   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = wrap_add(rr_ptr_q, k);
         if (!gnt_any && elig[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
   end

   always_comb begin
      pend_d = '0;
      for (int i = 0; i < NUM_SRC; i++) pend_d = pend_d + PEND_W'(hv_d[i]);
   end

   // With no grant, the bus tag, value and source keep their last values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         bcast_q  <= 1'b0;
         tag_q    <= INVALID_TAG;
         val_q    <= '0;
         src_q    <= '0;
         drop_q   <= 1'b0;
         pend_q   <= '0;
      end else begin
         bcast_q <= gnt_any;
         drop_q  <= |inv_slot;
         pend_q  <= pend_d;
         if (gnt_any) begin
            rr_ptr_q <= wrap_add(gnt_idx, 1);
            tag_q    <= htag[gnt_idx];
            val_q    <= hval[gnt_idx];
            src_q    <= gnt_idx;
         end
      end
   end

   assign out_CDB_broadcast = bcast_q;
   assign out_CDB_tag       = tag_q;
   assign out_CDB_val       = val_q;
   assign out_CDB_src       = src_q;
   assign out_drop          = drop_q;
   assign out_pending       = pend_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter. It runs directed scenarios and then random
// traffic. A cycle reference model and a per-result scoreboard produce the
// expected values.
module tb_cdb_arbiter;
   localparam int         N   = 4;
   localparam int         TW  = 5;
   localparam int         VW  = 32;
   localparam logic [4:0] INV = 5'b11111;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  vld = '0;
   logic [TW*N-1:0] tagv = '0;
   logic [VW*N-1:0] valv = '0;

   logic [N-1:0]  rdy;
   logic          bc, drop;
   logic [TW-1:0] ctag;
   logic [VW-1:0] cval;
   logic [1:0]    csrc;
   logic [2:0]    pend;

   cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .VAL_W(VW), .INVALID_TAG(INV)) dut (
      .clk(clk), .rst(rst), .in_src_valid(vld), .in_src_tag(tagv), .in_src_val(valv),
      .out_src_ready(rdy), .out_CDB_broadcast(bc), .out_CDB_tag(ctag), .out_CDB_val(cval),
      .out_CDB_src(csrc), .out_drop(drop), .out_pending(pend)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", t, obs, exp);
      end
   endtask

   // Reference model: slot contents, rotation pointer and expected outputs.
   bit          m_hv[N];
   logic [4:0]  m_tag[N];
   logic [31:0] m_val[N];
   int          m_rr = 0;
   bit          e_b = 0, e_drop = 0;
   logic [4:0]  e_tag = INV;
   logic [31:0] e_val = 0;
   int          e_src = 0, e_pend = 0;

   typedef struct { int src; logic [4:0] tag; logic [31:0] val; } ent_t;
   ent_t sbq[$];

   function automatic int m_grant();
      for (int k = 0; k < N; k++) begin
         int i = (m_rr + k) % N;
         if (m_hv[i] && m_tag[i] != INV) return i;
      end
      return -1;
   endfunction

   task automatic step();
      int g;
      logic [N-1:0] rdyv;
      bit found;
      g = m_grant();
      for (int i = 0; i < N; i++) rdyv[i] = rst ? 1'b1 : (!m_hv[i] || g == i);
      #1 chk("ready", 64'(rdy), 64'(rdyv));
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < N; i++) m_hv[i] = 0;
         m_rr = 0; e_b = 0; e_tag = INV; e_val = 0; e_src = 0; e_drop = 0; e_pend = 0;
         sbq.delete();
      end else begin
         e_drop = 0;
         for (int i = 0; i < N; i++)
            if (m_hv[i] && m_tag[i] == INV) begin e_drop = 1; m_hv[i] = 0; end
         if (g >= 0) begin
            e_b = 1; e_tag = m_tag[g]; e_val = m_val[g]; e_src = g;
            m_rr = (g + 1) % N; m_hv[g] = 0;
         end else e_b = 0;
         for (int i = 0; i < N; i++)
            if (vld[i] && rdyv[i]) begin
               ent_t e;
               m_hv[i] = 1; m_tag[i] = tagv[i*TW +: TW]; m_val[i] = valv[i*VW +: VW];
               e.src = i; e.tag = m_tag[i]; e.val = m_val[i];
               if (e.tag != INV) sbq.push_back(e);
            end
         e_pend = 0;
         for (int i = 0; i < N; i++) e_pend += int'(m_hv[i]);
      end
      #1;
      chk("bcast", 64'(bc), 64'(e_b));
      chk("tag", 64'(ctag), 64'(e_tag));
      chk("val", 64'(cval), 64'(e_val));
      chk("src", 64'(csrc), 64'(e_src));
      chk("drop", 64'(drop), 64'(e_drop));
      chk("pending", 64'(pend), 64'(e_pend));
      // Scoreboard: every broadcast must match the oldest accepted result of that source.
      if (bc === 1'b1) begin
         found = 0;
         for (int j = 0; j < sbq.size() && !found; j++)
            if (sbq[j].src == int'(csrc)) begin
               found = 1;
               chk("sb_tag", 64'(ctag), 64'(sbq[j].tag));
               chk("sb_val", 64'(cval), 64'(sbq[j].val));
               sbq.delete(j);
            end
         if (!found) chk("sb_unexpected", 64'(1), 64'(0));
      end
   endtask

   task automatic drive(input int i, input logic [4:0] t, input logic [31:0] v);
      vld[i] = 1'b1;
      tagv[i*TW +: TW] = t;
      valv[i*VW +: VW] = v;
   endtask

   task automatic idle();
      vld = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; vld = '0; step(); rst = 1'b0;
   endtask

   initial begin
      int cnt[N];
      int nb, dc;

      // Reset state and a single result.
      do_reset();
      chk("rst_tag", 64'(ctag), 64'(INV));
      chk("rst_pend", 64'(pend), 64'(0));
      drive(0, 5'd3, 32'h6); step(); idle();
      chk("s1_pend1", 64'(pend), 64'(1));
      step();
      chk("s1_bc", 64'(bc), 64'(1));
      chk("s1_tag", 64'(ctag), 64'(3));
      chk("s1_val", 64'(cval), 64'(6));
      chk("s1_pend0", 64'(pend), 64'(0));
      step();
      chk("s1_bc_off", 64'(bc), 64'(0));

      // Two sources at the same edge.
      do_reset();
      drive(1, 5'd2, 32'd7); drive(3, 5'd4, 32'd8); step(); idle();
      chk("s2_rdy3_lo", 64'(rdy[3]), 64'(0));
      step();
      chk("s2_first", 64'(csrc), 64'(1));
      chk("s2_rdy3_hi", 64'(rdy[3]), 64'(1));
      step();
      chk("s2_second", 64'(csrc), 64'(3));
      chk("s2_val", 64'(cval), 64'(8));

      // Fairness with all sources continuously valid.
      do_reset();
      for (int i = 0; i < N; i++) begin cnt[i] = 0; drive(i, 5'(i + 1), 32'(100 + i)); end
      nb = 0;
      for (int c = 0; c < 20 && nb < 12; c++) begin
         step();
         if (bc === 1'b1) begin
            chk("rr_order", 64'(csrc), 64'(nb % N));
            cnt[csrc]++; nb++;
         end
      end
      idle();
      chk("rr_total", 64'(nb), 64'(12));
      for (int i = 0; i < N; i++) chk("rr_count", 64'(cnt[i]), 64'(3));

      // Back-to-back on one source with no bubble.
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         drive(2, 5'(k), 32'(k * 16)); step();
         if (k > 1) begin
            chk("b2b_bc", 64'(bc), 64'(1));
            chk("b2b_tag", 64'(ctag), 64'(k - 1));
         end
      end
      idle(); step();
      chk("b2b_last", 64'(ctag), 64'(4));
      chk("b2b_last_bc", 64'(bc), 64'(1));
      step();
      chk("b2b_done", 64'(bc), 64'(0));

      // INVALID_TAG result is dropped and does not move the pointer.
      do_reset();
      drive(0, INV, 32'd9); drive(1, 5'd6, 32'd10); step(); idle();
      dc = 0; nb = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (drop === 1'b1) dc++;
         if (bc === 1'b1) begin nb++; chk("inv_tag", 64'(ctag), 64'(6)); end
      end
      chk("inv_drops", 64'(dc), 64'(1));
      chk("inv_bcasts", 64'(nb), 64'(1));
      drive(0, 5'd1, 32'd1); drive(2, 5'd2, 32'd2); step(); idle(); step();
      chk("inv_rr_src", 64'(csrc), 64'(2));
      step(); step();

      // Reset in the middle of operation.
      do_reset();
      drive(0, 5'd7, 32'd1); drive(1, 5'd8, 32'd2); drive(2, 5'd9, 32'd3); step(); idle();
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_bc", 64'(bc), 64'(0));
      chk("mid_tag", 64'(ctag), 64'(INV));
      chk("mid_pend", 64'(pend), 64'(0));
      step();
      chk("mid_quiet", 64'(bc), 64'(0));
      drive(1, 5'd10, 32'd4); drive(3, 5'd11, 32'd5); step(); idle(); step();
      chk("mid_rr0", 64'(csrc), 64'(1));
      step();
      chk("mid_next", 64'(csrc), 64'(3));

      // Random traffic with occasional resets and invalid tags.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < N; i++) begin
            vld[i] = ($urandom_range(0, 9) < 6);
            tagv[i*TW +: TW] = ($urandom_range(0, 7) == 0) ? INV : 5'($urandom_range(0, 30));
            valv[i*VW +: VW] = $urandom;
         end
         step();
      end
      rst = 1'b0; idle();
      for (int c = 0; c < 6; c++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
